osc_fft_frame_sched: RTL and testbench
======================================

# osc_fft_frame_sched

Frame scheduler for the oscilloscope's 256-point FFT. It sequences one frame at a time: mode configuration, then N real ADC samples fed over the FFT core's AXI4-stream input with `tvalid`/`tready`/`tlast`. It then waits for the core's last output sample and runs a programmable inter-frame gap in continuous mode. It sits between the ADC sample path and the FFT core's `i_axi4s_*` ports; its control inputs and status outputs connect to the scope control registers.

## Interface
- `LOG2_FFT_LEN`, 8, log2 of frame length; N = 2^LOG2_FFT_LEN.
- `INPUT_WIDTH`, 16, ADC sample width (signed).
- `DATAIN_WIDTH`, 16, byte-padded lane width of FFT input; must be ≥ INPUT_WIDTH.
- `GAP_WIDTH`, 16, width of the gap-length input.
- `TIMEOUT_CYCLES`, 4096, output watchdog limit, in cycles.

Ports:
- `i_aclk`  in  1  clock; all logic on rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  arm pulse; honoured only in IDLE.
- `i_continuous`  in  1  1 = re-arm after each frame; sampled at frame completion.
- `i_gap`  in  GAP_WIDTH  idle cycles between frames.
- `i_fft_mode`  in  1  mode bit; latched on start and at each CFG entry.
- `i_smp_valid`  in  1  ADC sample strobe; cannot be back-pressured.
- `i_smp_data`  in  INPUT_WIDTH  ADC sample.
- `o_cfg_tvalid`  out  1  config strobe to FFT.
- `o_cfg_tdata`  out  1  config mode bit.
- `o_data_tvalid`  out  1  FFT input valid.
- `o_data_tdata`  out  2*DATAIN_WIDTH  {im, re}, each lane DATAIN_WIDTH wide.
- `o_data_tlast`  out  1  last sample of frame.
- `i_data_tready`  in  1  FFT input ready.
- `i_out_tvalid`  in  1  FFT output valid (monitor only).
- `i_out_tlast`  in  1  FFT output last (monitor only).
- `o_busy`  out  1  state ≠ IDLE.
- `o_frame_done`  out  1  one-cycle pulse when the FFT output frame completes.
- `o_timeout`  out  1  one-cycle pulse on watchdog expiry.
- `o_drop_cnt`  out  16  saturating count of dropped samples.

## Operation
- States: IDLE, CFG, FEED, WAIT_OUT, GAP.
- IDLE
  - `i_start` → latch `i_fft_mode`, clear `o_drop_cnt`, go to CFG.
- CFG
  - `o_cfg_tvalid`=1 for exactly one cycle, `o_cfg_tdata`=latched mode.
  - Next state is FEED; sample counter cleared.
- FEED
  - Single-entry holding register (`hold_v`, `hold_d`).
  - `i_smp_valid` with holding register empty, or with the holding register transferring this cycle → capture the sample.
  - `i_smp_valid` with holding register full and not transferring → sample dropped, `o_drop_cnt`+1, saturating at 16'hFFFF.
  - Sample captures stop once N samples have been captured.
  - `o_data_tvalid`=`hold_v`. Re lane = `hold_d` sign-extended to DATAIN_WIDTH; im lane = 0.
  - Transfer = `o_data_tvalid & i_data_tready`; each transfer increments the counter.
  - `o_data_tlast`=1 while counter = N−1.
  - The transfer with `tlast` set → WAIT_OUT.
- WAIT_OUT
  - Samples ignored; not counted as drops.
  - `i_out_tvalid & i_out_tlast` → `o_frame_done` pulse. Then `i_continuous`=1 → GAP; else → IDLE.
  - Watchdog counts cycles spent in WAIT_OUT. Reaching TIMEOUT_CYCLES → `o_timeout` pulse, → IDLE, no `o_frame_done`.
- GAP
  - Counts `i_gap` cycles, then CFG (`i_fft_mode` re-latched).
  - `i_gap`=0 → CFG on the next cycle.
  - `i_continuous` dropped during GAP → IDLE.
- `i_start` outside IDLE is ignored.
- Samples outside FEED are discarded silently.

## Timing
- Reset value of every output is 0; state = IDLE; holding register empty; counters 0.
- Reset mid-frame aborts immediately, and the FFT sees a truncated frame. The system is responsible for also resetting the core.
- Start latency: `i_start` at cycle t → `o_cfg_tvalid` at t+1 → FEED from t+2.
- Sample latency: `i_smp_valid` at cycle t → `o_data_tvalid` at t+1. Throughput is one sample per cycle when `i_data_tready`=1.
- `o_data_tdata` and `o_data_tlast` remain stable while `tvalid`=1 and `tready`=0.
- Same-cycle transfer and new sample → no drop; the holding register reloads.
- `o_frame_done` and `o_timeout` are registered and mutually exclusive. If the output `tlast` arrives on the same cycle the watchdog expires, `o_frame_done` wins.
- Frame period in continuous mode = feed time + FFT latency + `i_gap` + 1 (CFG).

## Configuration
- `OSC_FFT_SCHED_TIMEOUT_EN` defined: watchdog counter present; behaviour as above.
- `OSC_FFT_SCHED_TIMEOUT_EN` undefined: no watchdog logic; WAIT_OUT waits indefinitely for the output `tlast`; `o_timeout` tied to 0.

## Test plan
- Single frame: reset, `i_start`, 256 consecutive samples 0..255, `i_data_tready`=1.
  - Expect one cfg pulse, 256 transfers with re = 0..255 and im = 0, `tlast` on value 255, `o_drop_cnt`=0.
  - Output `tlast` 100 cycles later → `o_frame_done`=1 for one cycle, `o_busy`=0 the next cycle.
- Back-pressure: `i_data_tready` low for 3 cycles mid-frame while samples arrive every cycle.
  - Expect `o_drop_cnt`=2, data held stable while stalled, `tlast` on the 256th accepted sample.
- Continuous mode: `i_continuous`=1, `i_gap`=10.
  - Expect the second `o_cfg_tvalid` exactly 11 cycles after `o_frame_done`.
  - Clearing `i_continuous` during GAP → IDLE.
- Timeout (macro defined): no output `tlast`.
  - Expect `o_timeout` exactly 4096 cycles after WAIT_OUT entry, then IDLE.
- Async reset asserted mid-FEED (sample 100): all outputs 0 immediately; a subsequent `i_start` runs a clean 256-sample frame.

Source files
------------

// File: rtl/osc_fft_frame_sched.sv
// Frame scheduler for the oscilloscope 256-point FFT: config strobe, N-sample AXI4-stream feed,
// output-frame wait and inter-frame gap. Define OSC_FFT_SCHED_TIMEOUT_EN to build the output watchdog.
module osc_fft_frame_sched #(
    parameter int LOG2_FFT_LEN   = 8,
    parameter int INPUT_WIDTH    = 16,
    parameter int DATAIN_WIDTH   = 16,
    parameter int GAP_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      i_aclk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_continuous,
    input  logic [GAP_WIDTH-1:0]      i_gap,
    input  logic                      i_fft_mode,
    input  logic                      i_smp_valid,
    input  logic [INPUT_WIDTH-1:0]    i_smp_data,
    output logic                      o_cfg_tvalid,
    output logic                      o_cfg_tdata,
    output logic                      o_data_tvalid,
    output logic [2*DATAIN_WIDTH-1:0] o_data_tdata,
    output logic                      o_data_tlast,
    input  logic                      i_data_tready,
    input  logic                      i_out_tvalid,
    input  logic                      i_out_tlast,
    output logic                      o_busy,
    output logic                      o_frame_done,
    output logic                      o_timeout,
    output logic [15:0]               o_drop_cnt
);
    localparam int N = 1 << LOG2_FFT_LEN;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CFG      = 3'd1,
        FEED     = 3'd2,
        WAIT_OUT = 3'd3,
        GAP      = 3'd4
    } state_t;

    state_t                         state;
    logic                           hold_v;
    logic signed [INPUT_WIDTH-1:0]  hold_d;
    logic [LOG2_FFT_LEN-1:0]        xfer_cnt;
    logic [LOG2_FFT_LEN:0]          cap_cnt;
    logic [GAP_WIDTH-1:0]           gap_cnt;
    logic                           xfer;
    logic                           room;
    logic                           capture;
    logic                           drop;
    logic                           out_last;
    logic                           wd_expire;
    logic signed [DATAIN_WIDTH-1:0] re_lane;

    assign xfer     = hold_v & i_data_tready;
    assign room     = cap_cnt < (LOG2_FFT_LEN+1)'(N);
    // A sample may enter when the holding slot is empty or is being emptied on this same edge.
    assign capture  = (state == FEED) & i_smp_valid & room & (~hold_v | xfer);
    assign drop     = (state == FEED) & i_smp_valid & room & hold_v & ~xfer;
    assign out_last = i_out_tvalid & i_out_tlast;

    assign re_lane       = DATAIN_WIDTH'(hold_d);
    assign o_data_tvalid = hold_v;
    assign o_data_tdata  = {{DATAIN_WIDTH{1'b0}}, re_lane};
    assign o_data_tlast  = hold_v & (xfer_cnt == LOG2_FFT_LEN'(N - 1));
    assign o_busy        = (state != IDLE);

`ifdef OSC_FFT_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    assign wd_expire = (state == WAIT_OUT) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts cycles spent in WAIT_OUT, zero elsewhere.
    always_ff @(posedge i_aclk or posedge i_rst) begin
        if (i_rst) begin
            wd_cnt <= {WD_W{1'b0}};
        end else if (state != WAIT_OUT) begin
            wd_cnt <= {WD_W{1'b0}};
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    // Frame sequencer, holding register, counters and registered status pulses.
    always_ff @(posedge i_aclk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            hold_v       <= 1'b0;
            hold_d       <= {INPUT_WIDTH{1'b0}};
            xfer_cnt     <= {LOG2_FFT_LEN{1'b0}};
            cap_cnt      <= {(LOG2_FFT_LEN+1){1'b0}};
            gap_cnt      <= {GAP_WIDTH{1'b0}};
            o_cfg_tvalid <= 1'b0;
            o_cfg_tdata  <= 1'b0;
            o_frame_done <= 1'b0;
            o_timeout    <= 1'b0;
            o_drop_cnt   <= 16'h0000;
        end else begin
            o_cfg_tvalid <= 1'b0;
            o_frame_done <= 1'b0;
            o_timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state        <= CFG;
                        o_cfg_tvalid <= 1'b1;
                        o_cfg_tdata  <= i_fft_mode;
                        o_drop_cnt   <= 16'h0000;
                    end
                end
                CFG: begin
                    state    <= FEED;
                    hold_v   <= 1'b0;
                    xfer_cnt <= {LOG2_FFT_LEN{1'b0}};
                    cap_cnt  <= {(LOG2_FFT_LEN+1){1'b0}};
                end
                FEED: begin
                    if (capture) begin
                        hold_v  <= 1'b1;
                        hold_d  <= i_smp_data;
                        cap_cnt <= cap_cnt + (LOG2_FFT_LEN+1)'(1);
                    end else if (xfer) begin
                        hold_v <= 1'b0;
                    end
                    if (drop && (o_drop_cnt != 16'hFFFF)) begin
                        o_drop_cnt <= o_drop_cnt + 16'd1;
                    end
                    if (xfer) begin
                        xfer_cnt <= xfer_cnt + LOG2_FFT_LEN'(1);
                        if (o_data_tlast) begin
                            state <= WAIT_OUT;
                        end
                    end
                end
                WAIT_OUT: begin
                    // Output tlast wins over a watchdog expiry on the same edge.
                    if (out_last) begin
                        o_frame_done <= 1'b1;
                        gap_cnt      <= {GAP_WIDTH{1'b0}};
                        state        <= i_continuous ? GAP : IDLE;
                    end else if (wd_expire) begin
                        o_timeout <= 1'b1;
                        state     <= IDLE;
                    end
                end
                GAP: begin
                    if (!i_continuous) begin
                        state <= IDLE;
                    end else if (gap_cnt == i_gap) begin
                        state        <= CFG;
                        o_cfg_tvalid <= 1'b1;
                        o_cfg_tdata  <= i_fft_mode;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_WIDTH'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_osc_fft_frame_sched.sv
// Directed self-checking bench for osc_fft_frame_sched: single frame, back-pressure, continuous
// mode with gap, watchdog (or its absence) and asynchronous reset mid-frame.
module tb_osc_fft_frame_sched;
    logic        clk;
    logic        rst;
    logic        start;
    logic        continuous;
    logic [15:0] gap;
    logic        fft_mode;
    logic        smp_valid;
    logic [15:0] smp_data;
    logic        cfg_tvalid;
    logic        cfg_tdata;
    logic        data_tvalid;
    logic [31:0] data_tdata;
    logic        data_tlast;
    logic        data_tready;
    logic        out_tvalid;
    logic        out_tlast;
    logic        busy;
    logic        frame_done;
    logic        timeout;
    logic [15:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    osc_fft_frame_sched dut (
        .i_aclk        (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_continuous  (continuous),
        .i_gap         (gap),
        .i_fft_mode    (fft_mode),
        .i_smp_valid   (smp_valid),
        .i_smp_data    (smp_data),
        .o_cfg_tvalid  (cfg_tvalid),
        .o_cfg_tdata   (cfg_tdata),
        .o_data_tvalid (data_tvalid),
        .o_data_tdata  (data_tdata),
        .o_data_tlast  (data_tlast),
        .i_data_tready (data_tready),
        .i_out_tvalid  (out_tvalid),
        .i_out_tlast   (out_tlast),
        .o_busy        (busy),
        .o_frame_done  (frame_done),
        .o_timeout     (timeout),
        .o_drop_cnt    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // IDLE -> CFG -> FEED; a stray sample on the CFG edge must never reach the stream.
    task automatic start_frame(input logic mode);
        fft_mode = mode;
        start    = 1'b1;
        step();
        start = 1'b0;
        check("cfg_pulse", cfg_tvalid, 1'b1);
        check("cfg_mode", cfg_tdata, mode);
        check("busy_cfg", busy, 1'b1);
        smp_valid = 1'b1;
        smp_data  = 16'hBEEF;
        step();
        smp_valid = 1'b0;
        check("cfg_one_cycle", cfg_tvalid, 1'b0);
    endtask

    // Drives the sample stream from the first FEED cycle and checks every accepted transfer.
    // Optional: one idle sample slot at cycle gap_at, then tready low for stall_len cycles.
    // Values above skip_from appear shifted by skip (samples lost to drops).
    task automatic feed(input int gap_at, input int stall_len, input int skip_from,
                        input int skip, input int stop_after);
        int          acc;
        int          cyc;
        int          v;
        logic        rdy;
        logic [15:0] exp_re;
        acc = 0;
        cyc = 0;
        v   = 0;
        while (acc < stop_after && cyc < 1000) begin
            rdy = 1'b1;
            if (cyc == gap_at) begin
                smp_valid = 1'b0;
            end else begin
                smp_valid = 1'b1;
                smp_data  = 16'(v);
                v++;
                if (gap_at >= 0 && cyc > gap_at && cyc <= gap_at + stall_len) rdy = 1'b0;
            end
            data_tready = rdy;
            exp_re = 16'((acc > skip_from) ? acc + skip : acc);
            if (data_tvalid && rdy) begin
                check("xfer_data", data_tdata, {16'h0000, exp_re});
                check("xfer_last", data_tlast, (acc == 255));
                acc++;
            end else if (data_tvalid) begin
                check("stall_hold", data_tdata, {16'h0000, exp_re});
            end
            step();
            cyc++;
        end
        smp_valid   = 1'b0;
        data_tready = 1'b1;
        check("feed_count", acc, stop_after);
    endtask

    task automatic out_last_pulse();
        out_tvalid = 1'b1;
        out_tlast  = 1'b1;
        step();
        out_tvalid = 1'b0;
        out_tlast  = 1'b0;
    endtask

    initial begin
        int n;
        int n_to;
        rst         = 1'b1;
        start       = 1'b0;
        continuous  = 1'b0;
        gap         = 16'd0;
        fft_mode    = 1'b0;
        smp_valid   = 1'b0;
        smp_data    = 16'h0000;
        data_tready = 1'b1;
        out_tvalid  = 1'b0;
        out_tlast   = 1'b0;
        step();
        step();
        check("rst_cfg_tvalid", cfg_tvalid, 1'b0);
        check("rst_data_tvalid", data_tvalid, 1'b0);
        check("rst_tdata", data_tdata, 32'h0);
        check("rst_tlast", data_tlast, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_drop", drop_cnt, 16'h0);
        rst = 1'b0;
        step();

        // Single frame, 0..255, no back-pressure, output tlast 100 cycles later.
        start_frame(1'b1);
        feed(-1, 0, 1000, 0, 256);
        check("f1_drop", drop_cnt, 16'd0);
        check("f1_tvalid_after", data_tvalid, 1'b0);
        repeat (99) step();
        check("f1_wait_busy", busy, 1'b1);
        check("f1_wait_nodone", frame_done, 1'b0);
        out_last_pulse();
        check("f1_done", frame_done, 1'b1);
        step();
        check("f1_done_pulse", frame_done, 1'b0);
        check("f1_idle", busy, 1'b0);

        // Back-pressure: slot empties, then 3 stalled cycles each bringing a sample -> 2 drops.
        start_frame(1'b0);
        feed(100, 3, 100, 2, 256);
        check("bp_drop", drop_cnt, 16'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_ignored", cfg_tvalid, 1'b0);
        check("start_ignored_busy", busy, 1'b1);
        out_last_pulse();
        check("bp_done", frame_done, 1'b1);
        step();

        // Continuous mode: gap 10 -> CFG 11 cycles after done, mode re-latched.
        continuous = 1'b1;
        gap        = 16'd10;
        start_frame(1'b0);
        fft_mode = 1'b1;
        feed(-1, 0, 1000, 0, 256);
        out_last_pulse();
        check("c1_done", frame_done, 1'b1);
        check("c1_busy_gap", busy, 1'b1);
        n = 0;
        while (!cfg_tvalid && n < 50) begin
            step();
            n++;
        end
        check("c1_gap_len", n, 11);
        check("c1_relatch", cfg_tdata, 1'b1);
        // gap 0 -> CFG on the cycle after done.
        gap = 16'd0;
        step();
        feed(-1, 0, 1000, 0, 256);
        out_last_pulse();
        check("c2_done", frame_done, 1'b1);
        n = 0;
        while (!cfg_tvalid && n < 50) begin
            step();
            n++;
        end
        check("c2_gap_len", n, 1);
        // Third frame: drop continuous mid-gap -> IDLE, no further CFG.
        gap = 16'd10;
        step();
        feed(-1, 0, 1000, 0, 256);
        out_last_pulse();
        check("c3_done", frame_done, 1'b1);
        step();
        continuous = 1'b0;
        step();
        check("c3_gap_abort", busy, 1'b0);
        n = 0;
        repeat (15) begin
            step();
            if (cfg_tvalid) n++;
        end
        check("c3_no_cfg", n, 0);
        check("c3_drop_total", drop_cnt, 16'd0);

        // Output watchdog: no output tlast.
        start_frame(1'b0);
        feed(-1, 0, 1000, 0, 256);
`ifdef OSC_FFT_SCHED_TIMEOUT_EN
        n = 0;
        while (!timeout && n < 5000) begin
            step();
            n++;
        end
        check("to_latency", n, 4096);
        check("to_idle", busy, 1'b0);
        check("to_no_done", frame_done, 1'b0);
        step();
        check("to_pulse", timeout, 1'b0);
`else
        n_to = 0;
        repeat (4200) begin
            step();
            if (timeout) n_to++;
        end
        check("no_timeout", n_to, 0);
        check("wait_forever", busy, 1'b1);
        out_last_pulse();
        check("late_done", frame_done, 1'b1);
        step();
`endif

        // Asynchronous reset with sample 100 in the holding register.
        start_frame(1'b1);
        feed(-1, 0, 1000, 0, 100);
        check("pre_rst_tvalid", data_tvalid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_tvalid", data_tvalid, 1'b0);
        check("arst_tdata", data_tdata, 32'h0);
        check("arst_busy", busy, 1'b0);
        check("arst_cfg", cfg_tdata, 1'b0);
        step();
        rst = 1'b0;
        step();
        start_frame(1'b0);
        feed(-1, 0, 1000, 0, 256);
        check("post_rst_drop", drop_cnt, 16'd0);
        out_last_pulse();
        check("post_rst_done", frame_done, 1'b1);
        step();
        check("post_rst_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
